keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 2400: clock cycles each row is driven before the next row; legal values are 3 or more.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 480000: consecutive stable cycles required to accept a press or a release; legal values are 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state is on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port s_cols, input, 4 bits: already-synchronized keypad columns, active-low (0 = key closed on the driven row).
REQ-006 SHALL have port rows, output, 4 bits: keypad row drive, one-hot active-low, with exactly one bit at 0 at all times.
REQ-007 SHALL have port key, output, 4 bits: hex code of the most recently accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: single-cycle strobe on each accepted press.

Function
REQ-009 SHALL use a four-state FSM: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-010 In SCAN, the dwell counter SHALL count 0..SCAN_CYCLES-1; at the terminal count rows SHALL rotate 1110->1101->1011->0111->1110.
REQ-011 In SCAN, s_cols SHALL be sampled only at the dwell terminal count, which absorbs the two-cycle synchronizer delay.
REQ-012 If the sample at the terminal count is not 4'b1111, the FSM SHALL latch the current row and the lowest-index low column, hold rows, clear the counter, and enter DEBOUNCE instead of rotating.
REQ-013 In DEBOUNCE, if the latched column reads 1, the FSM SHALL return to SCAN and advance to the next row.
REQ-014 In DEBOUNCE, if the latched column has read 0 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL update key, assert key_valid for exactly one cycle, and enter HELD.
REQ-015 Key map (row r / col c) SHALL be: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-016 In HELD, rows SHALL stay on the latched row; other columns SHALL be ignored (no rollover); the FSM SHALL enter RELEASE with the counter cleared when the latched column reads 1.
REQ-017 In RELEASE, a 0 on the latched column SHALL return the FSM to HELD with no new strobe.
REQ-018 In RELEASE, after DEBOUNCE_CYCLES consecutive 1s the FSM SHALL enter SCAN on the next row with the dwell counter cleared.
REQ-019 key SHALL hold its value between presses; it SHALL change only on the cycle key_valid asserts.
REQ-020 Holding a key SHALL produce exactly one key_valid, regardless of hold duration.
REQ-021 Counters SHALL be sized $clog2 of the larger parameter and SHALL never wrap while in use.

Reset
REQ-022 While reset=0: state=SCAN, rows=4'b1110, dwell/debounce counters=0, key=4'h0, key_valid=0, latched row/col=0.
REQ-023 Reset asserted mid-press SHALL abort any press without a strobe; after release of reset, scanning SHALL restart at row 0.

Structure
REQ-024 Package keypad_pkg SHALL hold the state enum, the row-reset constant 4'b1110, and the key-map function.
REQ-025 Sub-module keypad_decode SHALL be combinational: inputs are latched row index and column index (2 bits each); output is the 4-bit hex code.
REQ-026 The synchronizer SHALL remain external; keypad_scanner SHALL NOT re-synchronize s_cols.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, key model drives s_cols from rows)
REQ-027 Idle, no key pressed -> rows cycle 1110,1101,1011,0111 every 4 clocks; key_valid never asserts.
REQ-028 Key "5" (r1, c1) held 40 cycles -> rows stop at 1101; one key_valid pulse with key=4'h5 at 8 cycles after detection; rows resume rotating 8 cycles after release.
REQ-029 Key "D" pressed with 3-cycle bounce (0/1 toggling) then held -> at most one strobe with key=4'hD, and none before 8 stable cycles.
REQ-030 "1" held, then "9" added, then "1" released -> exactly one strobe (4'h1); "9" is accepted only after the release debounce, via the next scan, as 4'h9.
REQ-031 reset pulsed low during DEBOUNCE of "A" -> key_valid=0, key=0, rows=1110 asynchronously; scanning restarts at row 0.
REQ-032 Columns 1 and 3 both low on r2 -> latched col 1, key=4'h8.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and key-map helpers for the 4x4 keypad scanner.
// The key map follows the printed keypad legend, row by row.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      4'd15:   code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index active-low column wins when several read closed.
  function automatic logic [1:0] first_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    if (cols[0] == 1'b0) begin
      idx = 2'd0;
    end else if (cols[1] == 1'b0) begin
      idx = 2'd1;
    end else if (cols[2] == 1'b0) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational translation of a latched row/column position to its hex key code.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] code
);

  assign code = key_map(row, col);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low row drive, debounces press and release
// of a single key, and strobes key_valid once per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 2400,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s_cols,
  output logic [3:0] rows,
  output logic [3:0] key,
  output logic       key_valid
);

  localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       row_idx_r, row_idx_s;
  logic [1:0]       lat_row_r, lat_row_s;
  logic [1:0]       lat_col_r, lat_col_s;
  logic [3:0]       rows_r, rows_s;
  logic [3:0]       key_r, key_s;
  logic             key_valid_r, key_valid_s;
  logic [3:0]       code_s;
  logic             col_open_s;

  keypad_decode u_decode (
    .row  (lat_row_r),
    .col  (lat_col_r),
    .code (code_s)
  );

  // Next-state, counter, row-select and key-capture logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    row_idx_s   = row_idx_r;
    lat_row_s   = lat_row_r;
    lat_col_s   = lat_col_r;
    key_s       = key_r;
    key_valid_s = 1'b0;
    col_open_s  = s_cols[lat_col_r];

    case (state_r)
      ST_SCAN: begin
        if (cnt_r == SCAN_LAST) begin
          cnt_s = '0;
          if (s_cols != 4'b1111) begin
            lat_row_s = row_idx_r;
            lat_col_s = first_low_col(s_cols);
            state_s   = ST_DEBOUNCE;
          end else begin
            row_idx_s = row_idx_r + 2'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (col_open_s) begin
          state_s   = ST_SCAN;
          cnt_s     = '0;
          row_idx_s = row_idx_r + 2'd1;
        end else if (cnt_r == DEB_LAST) begin
          key_s       = code_s;
          key_valid_s = 1'b1;
          state_s     = ST_HELD;
          cnt_s       = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        // Other columns are ignored here: no rollover while a key is held.
        cnt_s = '0;
        if (col_open_s) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_HELD;
        end
      end
      ST_RELEASE: begin
        if (!col_open_s) begin
          state_s = ST_HELD;
          cnt_s   = '0;
        end else if (cnt_r == DEB_LAST) begin
          state_s   = ST_SCAN;
          cnt_s     = '0;
          row_idx_s = row_idx_r + 2'd1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = ST_SCAN;
        cnt_s     = '0;
        row_idx_s = 2'd0;
      end
    endcase

    rows_s = ~(4'b0001 << row_idx_s);
  end

  // State and output registers; reset aborts any press in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_SCAN;
      cnt_r       <= '0;
      row_idx_r   <= 2'd0;
      lat_row_r   <= 2'd0;
      lat_col_r   <= 2'd0;
      rows_r      <= ROW_RESET;
      key_r       <= 4'h0;
      key_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      row_idx_r   <= row_idx_s;
      lat_row_r   <= lat_row_s;
      lat_col_r   <= lat_col_s;
      rows_r      <= rows_s;
      key_r       <= key_s;
      key_valid_r <= key_valid_s;
    end
  end

  assign rows      = rows_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model with a two-flop column
// synchronizer, directed scenarios plus randomized presses against timing rules.
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DEB  = 8;
  // Press on the row before the target, so detection lands on the next dwell end.
  localparam int PRESS_LAT   = 2 * SCAN + DEB;
  // Sync delay (2) + one HELD sample + DEB release samples.
  localparam int RELEASE_LAT = 3 + DEB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s_cols;
  logic [3:0] rows;
  logic [3:0] key;
  logic       key_valid;

  logic [15:0] pressed = 16'h0000;
  logic [3:0]  raw;
  logic [3:0]  sync1 = 4'hF;
  logic [3:0]  sync2 = 4'hF;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int strobe_cyc = 0;
  int key_chg_err = 0;
  int onehot_err = 0;
  logic [3:0] last_key = 4'h0;
  logic [3:0] prev_key = 4'h0;

  logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_cols    (s_cols),
    .rows      (rows),
    .key       (key),
    .key_valid (key_valid)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    raw = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (rows[r] == 1'b0) raw = raw & ~pressed[r*4 +: 4];
    end
  end

  always @(posedge clk) begin
    sync1 <= raw;
    sync2 <= sync1;
    cyc   <= cyc + 1;
  end
  assign s_cols = sync2;

  always @(negedge clk) begin
    if ($countones(~rows) != 1) onehot_err <= onehot_err + 1;
    if (!reset) begin
      prev_key <= key;
    end else begin
      if (key_valid) begin
        strobes    <= strobes + 1;
        last_key   <= key;
        strobe_cyc <= cyc;
      end else if (key !== prev_key) begin
        key_chg_err <= key_chg_err + 1;
      end
      prev_key <= key;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for the scan to arrive on the row before r, then close the keys in mask.
  task automatic press_key(input int r, input logic [3:0] mask, output int pcyc);
    logic [3:0] target, old;
    bit found;
    target = rot[(r + 3) % 4];
    old = rows;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rows == target && old != target) found = 1'b1;
      else old = rows;
    end
    if (!found) chk("press_timeout", 32'd0, 32'd1);
    pressed[r*4 +: 4] = mask;
    pcyc = cyc;
  endtask

  task automatic wait_rows_change(input logic [3:0] from, output int ccyc);
    bit found;
    found = 1'b0;
    ccyc = cyc;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (rows != from) begin
        found = 1'b1;
        ccyc = cyc;
      end
    end
    if (!found) chk("rows_change_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c0, pc, rc, cc, base, t, r, c, hold;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_rows", rows, 4'b1110);
    chk("reset_key", key, 4'h0);
    chk("reset_valid", key_valid, 1'b0);
    reset = 1'b1;
    c0 = cyc;

    // Idle rotation.
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("idle_rows", rows, rot[((cyc - c0) / SCAN) % 4]);
    end
    chk("idle_no_strobe", strobes, 0);

    // Key 5 held 40 cycles.
    base = strobes;
    press_key(1, 4'b0010, pc);
    repeat (40) @(negedge clk);
    chk("k5_strobes", strobes - base, 1);
    chk("k5_key", last_key, 4'h5);
    chk("k5_latency", strobe_cyc - pc, PRESS_LAT);
    chk("k5_rows_held", rows, 4'b1101);
    pressed = 16'h0000;
    rc = cyc;
    wait_rows_change(4'b1101, cc);
    chk("k5_release_lat", cc - rc, RELEASE_LAT);
    chk("k5_next_row", rows, 4'b1011);

    // Key D with bounce during debounce.
    base = strobes;
    press_key(3, 4'b1000, pc);
    repeat (9) @(negedge clk);
    pressed[15] = 1'b0;
    @(negedge clk) pressed[15] = 1'b1;
    @(negedge clk) pressed[15] = 1'b0;
    @(negedge clk) pressed[15] = 1'b1;
    t = cyc;
    repeat (80) @(negedge clk);
    chk("kd_strobes", strobes - base, 1);
    chk("kd_key", last_key, 4'hD);
    chk("kd_stable_first", (strobe_cyc - t) >= DEB, 1'b1);
    pressed = 16'h0000;
    wait_rows_change(4'b0111, cc);

    // Rollover: 1 held, 9 added, 1 released.
    base = strobes;
    press_key(0, 4'b0001, pc);
    repeat (20) @(negedge clk);
    chk("k1_key", last_key, 4'h1);
    pressed[10] = 1'b1;
    repeat (20) @(negedge clk);
    chk("k1_no_rollover", strobes - base, 1);
    chk("k1_rows_held", rows, 4'b1110);
    pressed[0] = 1'b0;
    for (int i = 0; i < 100 && strobes - base < 2; i++) @(negedge clk);
    chk("k9_strobes", strobes - base, 2);
    chk("k9_key", last_key, 4'h9);
    pressed = 16'h0000;
    repeat (30) @(negedge clk);

    // Reset during debounce of A.
    base = strobes;
    press_key(0, 4'b1000, pc);
    repeat (11) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstA_rows", rows, 4'b1110);
    chk("rstA_key", key, 4'h0);
    chk("rstA_valid", key_valid, 1'b0);
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rstA_restart_rows", rows, rot[((cyc - c0) / SCAN) % 4]);
    end
    chk("rstA_no_strobe", strobes - base, 0);

    // Columns 1 and 3 together on row 2.
    base = strobes;
    press_key(2, 4'b1010, pc);
    repeat (25) @(negedge clk);
    chk("k8_strobes", strobes - base, 1);
    chk("k8_key", last_key, 4'h8);
    pressed = 16'h0000;
    wait_rows_change(4'b1011, cc);

    // Randomized single presses.
    for (int n = 0; n < 6; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      hold = $urandom_range(PRESS_LAT + 4, 60);
      base = strobes;
      press_key(r, 4'(4'b0001 << c), pc);
      repeat (hold) @(negedge clk);
      chk("rand_strobes", strobes - base, 1);
      chk("rand_key", last_key, kmap[r*4 + c]);
      chk("rand_latency", strobe_cyc - pc, PRESS_LAT);
      chk("rand_rows_held", rows, rot[r]);
      pressed = 16'h0000;
      rc = cyc;
      wait_rows_change(rot[r], cc);
      chk("rand_release_lat", cc - rc, RELEASE_LAT);
      chk("rand_next_row", rows, rot[(r + 1) % 4]);
    end

    chk("rows_onehot", onehot_err, 0);
    chk("key_stable_between", key_chg_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
